irq_priority_ctrl: RTL and testbench

- Nested-priority interrupt controller for the interrupt pipeline CPU.
- Synchronises the raw IRQ lines and edge-detects them into a pending register.
- Selects the highest-priority eligible source and hands it to the pipeline with a req/ack handshake.
- Tracks in-service levels so a higher IRQ can preempt a running handler; eret retires the current level.

---
 rtl/irq_pkg.sv | 26 ++
 rtl/irq_priority_ctrl_if.sv | 35 +++
 rtl/irq_sync_edge.sv | 28 ++
 rtl/irq_priority_ctrl.sv | 144 ++++++++++++++
 tb/tb_irq_priority_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared constants, state encoding and priority helper for the nested interrupt controller.
package irq_pkg;

  localparam int NUM_IRQ = 3;
  localparam int WIDTH   = 32;
  localparam int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [WIDTH-1:0] VEC_BASE   = 32'h0000_0100;
  localparam logic [WIDTH-1:0] VEC_STRIDE = 32'h0000_0010;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] TAKEN = 2'd2;

  // Index of the most significant set bit; 0 when no bit is set, so callers
  // must qualify the result with a reduction-OR of the same vector.
  function automatic logic [ID_W-1:0] highest_set(input logic [NUM_IRQ-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (v[i]) idx = i[ID_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_priority_ctrl_if.sv
// Pipeline-facing bundle of the interrupt controller; int_vec exists only with IRQ_VECTOR_EN.
interface irq_priority_ctrl_if;
  import irq_pkg::*;

  logic [NUM_IRQ-1:0] irq;
  logic               ie;
  logic               int_ack;
  logic               eret;
  logic               int_req;
  logic [ID_W-1:0]    int_id;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] in_service;
`ifdef IRQ_VECTOR_EN
  logic [WIDTH-1:0]   int_vec;
`endif

  // master: the controller, which raises requests towards the pipeline
  modport master (
    input  irq, ie, int_ack, eret,
    output int_req, int_id, pending, in_service
`ifdef IRQ_VECTOR_EN
    , output int_vec
`endif
  );

  // slave: the CPU pipeline, which answers with ack/eret
  modport slave (
    output irq, ie, int_ack, eret,
    input  int_req, int_id, pending, in_service
`ifdef IRQ_VECTOR_EN
    , input int_vec
`endif
  );

endinterface

// File: rtl/irq_sync_edge.sv
// Three-flop synchroniser for one raw IRQ line with rising-edge detect on the settled copy.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq_line,
  output logic edge_det
);

  logic s1_reg;
  logic s2_reg;
  logic s3_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= irq_line;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  // s1 may be metastable; only s2/s3 feed logic
  assign edge_det = s2_reg & ~s3_reg;

endmodule

// File: rtl/irq_priority_ctrl.sv
// Nested-priority interrupt controller: pending latch, preemption by level, req/ack/eret handshake.
// Define IRQ_VECTOR_EN to add the registered int_vec handler address output.
module irq_priority_ctrl
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  irq_priority_ctrl_if.master bus
);

  logic [NUM_IRQ-1:0] edge_vec;

  logic [1:0]         state_reg;
  logic [1:0]         state_next;
  logic [NUM_IRQ-1:0] pending_reg;
  logic [NUM_IRQ-1:0] pending_next;
  logic [NUM_IRQ-1:0] in_service_reg;
  logic [NUM_IRQ-1:0] in_service_next;
  logic               int_req_reg;
  logic               int_req_next;
  logic [ID_W-1:0]    int_id_reg;
  logic [ID_W-1:0]    int_id_next;
`ifdef IRQ_VECTOR_EN
  logic [WIDTH-1:0]   int_vec_reg;
  logic [WIDTH-1:0]   int_vec_next;
`endif

  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
      irq_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .irq_line (bus.irq[gi]),
        .edge_det (edge_vec[gi])
      );
    end
  endgenerate

  logic [ID_W-1:0]    cand;
  logic               cand_valid;
  logic [ID_W-1:0]    isr_top;
  logic               isr_busy;
  logic               cand_ok;
  logic               cur_ok;
  logic               ack_acc;
  logic [NUM_IRQ-1:0] ack_mask;
  logic [NUM_IRQ-1:0] eret_mask;

  assign cand       = highest_set(pending_reg);
  assign cand_valid = |pending_reg;
  assign isr_top    = highest_set(in_service_reg);
  assign isr_busy   = |in_service_reg;

  // A source may only interrupt a handler of strictly lower priority.
  assign cand_ok = bus.ie && cand_valid && (!isr_busy || (cand > isr_top));
  assign cur_ok  = bus.ie && (!isr_busy || (int_id_reg > isr_top));

  assign ack_acc   = (state_reg == REQ) && bus.int_ack;
  assign ack_mask  = ack_acc ? (NUM_IRQ'(1) << int_id_reg) : '0;
  assign eret_mask = (bus.eret && isr_busy) ? (NUM_IRQ'(1) << isr_top) : '0;

  // A fresh edge of the acked source re-arms pending in the same cycle.
  assign pending_next    = (pending_reg & ~ack_mask) | edge_vec;
  // eret retires the pre-cycle top level before the acked level is pushed.
  assign in_service_next = (in_service_reg & ~eret_mask) | ack_mask;

  always_comb begin
    state_next   = state_reg;
    int_req_next = int_req_reg;
    int_id_next  = int_id_reg;
`ifdef IRQ_VECTOR_EN
    int_vec_next = int_vec_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (cand_ok) begin
          state_next   = REQ;
          int_req_next = 1'b1;
          int_id_next  = cand;
`ifdef IRQ_VECTOR_EN
          int_vec_next = VEC_BASE + (WIDTH'(cand) * VEC_STRIDE);
`endif
        end
      end
      REQ: begin
        if (bus.int_ack) begin
          state_next   = TAKEN;
          int_req_next = 1'b0;
`ifdef IRQ_VECTOR_EN
          int_vec_next = '0;
`endif
        end else if (!cur_ok) begin
          state_next   = IDLE;
          int_req_next = 1'b0;
`ifdef IRQ_VECTOR_EN
          int_vec_next = '0;
`endif
        end
      end
      TAKEN: begin
        // bubble while the pipeline redirects to the handler
        state_next = IDLE;
      end
      default: begin
        state_next   = IDLE;
        int_req_next = 1'b0;
`ifdef IRQ_VECTOR_EN
        int_vec_next = '0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      pending_reg    <= '0;
      in_service_reg <= '0;
      int_req_reg    <= 1'b0;
      int_id_reg     <= '0;
`ifdef IRQ_VECTOR_EN
      int_vec_reg    <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      in_service_reg <= in_service_next;
      int_req_reg    <= int_req_next;
      int_id_reg     <= int_id_next;
`ifdef IRQ_VECTOR_EN
      int_vec_reg    <= int_vec_next;
`endif
    end
  end

  assign bus.int_req    = int_req_reg;
  assign bus.int_id     = int_id_reg;
  assign bus.pending    = pending_reg;
  assign bus.in_service = in_service_reg;
`ifdef IRQ_VECTOR_EN
  assign bus.int_vec    = int_vec_reg;
`endif

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed plus randomized bench for irq_priority_ctrl against a stack-based reference model.
module tb_irq_priority_ctrl;
  import irq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  irq_priority_ctrl_if bus ();

  irq_priority_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // Reference model: raw samples history, pending bits, handler stack, request flags.
  logic [NUM_IRQ-1:0] samp_q[$];
  logic [NUM_IRQ-1:0] m_pend;
  int                 m_stack[$];
  bit                 m_req;
  bit                 m_bubble;
  int                 m_id;

  task automatic model_reset();
    samp_q = '{3'b000, 3'b000, 3'b000};
    m_pend = '0;
    m_stack.delete();
    m_req = 1'b0;
    m_bubble = 1'b0;
    m_id = 0;
  endtask

  function automatic logic [NUM_IRQ-1:0] model_isr();
    logic [NUM_IRQ-1:0] v;
    v = '0;
    foreach (m_stack[i]) v[m_stack[i]] = 1'b1;
    return v;
  endfunction

  task automatic model_step();
    logic [NUM_IRQ-1:0] e;
    logic [NUM_IRQ-1:0] new_pend;
    int top;
    int cand;
    bit acc;
    // samp_q[0] = sample one edge ago, [1] two ago, [2] three ago
    e = samp_q[1] & ~samp_q[2];
    samp_q.push_front(bus.irq);
    void'(samp_q.pop_back());
    top = (m_stack.size() > 0) ? m_stack[$] : -1;
    acc = m_req && bus.int_ack;
    new_pend = m_pend;
    if (acc) new_pend[m_id] = 1'b0;
    new_pend = new_pend | e;
    if (bus.eret && m_stack.size() > 0) void'(m_stack.pop_back());
    if (acc) m_stack.push_back(m_id);
    cand = -1;
    for (int i = 0; i < NUM_IRQ; i++) if (m_pend[i]) cand = i;
    if (m_bubble) begin
      m_bubble = 1'b0;
    end else if (m_req) begin
      if (bus.int_ack) begin
        m_req = 1'b0;
        m_bubble = 1'b1;
        $display("txn ack id=%0d in_service=%b", m_id, model_isr());
      end else if (!(bus.ie && m_id > top)) begin
        m_req = 1'b0;
      end
    end else if (cand >= 0 && bus.ie && cand > top) begin
      m_req = 1'b1;
      m_id = cand;
    end
    m_pend = new_pend;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] ev;
    chk("int_req", 32'(bus.int_req), 32'(m_req));
    if (m_req) chk("int_id", 32'(bus.int_id), 32'(m_id));
    chk("pending", 32'(bus.pending), 32'(m_pend));
    chk("in_service", 32'(bus.in_service), 32'(model_isr()));
`ifdef IRQ_VECTOR_EN
    ev = m_req ? (VEC_BASE + 32'(m_id) * VEC_STRIDE) : 32'h0;
    chk("int_vec", bus.int_vec, ev);
`else
    ev = 32'h0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic cyc(input logic [NUM_IRQ-1:0] irqv, input logic iev,
                     input logic ackv, input logic eretv);
    bus.irq = irqv;
    bus.ie = iev;
    bus.int_ack = ackv;
    bus.eret = eretv;
    tick();
    bus.int_ack = 1'b0;
    bus.eret = 1'b0;
  endtask

  task automatic async_reset();
    rst = 1'b0;
    bus.irq = '0;
    bus.int_ack = 1'b0;
    bus.eret = 1'b0;
    #1;
    model_reset();
    chk("rst_int_req", 32'(bus.int_req), 32'h0);
    chk("rst_int_id", 32'(bus.int_id), 32'h0);
    chk("rst_pending", 32'(bus.pending), 32'h0);
    chk("rst_in_service", 32'(bus.in_service), 32'h0);
`ifdef IRQ_VECTOR_EN
    chk("rst_int_vec", bus.int_vec, 32'h0);
`endif
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    bus.irq = '0;
    bus.ie = 1'b0;
    bus.int_ack = 1'b0;
    bus.eret = 1'b0;
    model_reset();
    async_reset();

    // Single edge: latency and ack
    cyc(3'b001, 1, 0, 0);
    cyc(3'b000, 1, 0, 0);
    chk("lat_pend_k1", 32'(bus.pending), 32'h0);
    cyc(3'b000, 1, 0, 0);
    chk("lat_pend_k2", 32'(bus.pending), 32'h1);
    chk("lat_req_k2", 32'(bus.int_req), 32'h0);
    cyc(3'b000, 1, 0, 0);
    chk("lat_req_k3", 32'(bus.int_req), 32'h1);
    chk("lat_id_k3", 32'(bus.int_id), 32'h0);
    cyc(3'b000, 1, 1, 0);
    chk("ack_isr", 32'(bus.in_service), 32'h1);
    chk("ack_pend", 32'(bus.pending), 32'h0);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 0, 1);
    chk("eret_isr", 32'(bus.in_service), 32'h0);

    // Priority between simultaneous sources
    cyc(3'b101, 1, 0, 0);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 0, 0);
    chk("prio_id", 32'(bus.int_id), 32'h2);
    cyc(3'b000, 1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(3'b000, 1, 0, 0);
    chk("prio_blocked", 32'(bus.int_req), 32'h0);
    cyc(3'b000, 1, 0, 1);
    cyc(3'b000, 1, 0, 0);
    chk("prio_after_eret_req", 32'(bus.int_req), 32'h1);
    chk("prio_after_eret_id", 32'(bus.int_id), 32'h0);

    // Nesting: IRQ2 preempts IRQ0
    cyc(3'b000, 1, 1, 0);
    cyc(3'b100, 1, 0, 0);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 0, 0);
    chk("nest_id", 32'(bus.int_id), 32'h2);
    cyc(3'b000, 1, 1, 0);
    chk("nest_isr", 32'(bus.in_service), 32'h5);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 0, 1);
    chk("nest_eret1", 32'(bus.in_service), 32'h1);
    cyc(3'b000, 1, 0, 1);
    chk("nest_eret2", 32'(bus.in_service), 32'h0);
    cyc(3'b000, 1, 0, 1);
    chk("nest_eret3", 32'(bus.in_service), 32'h0);

    // Masking and withdraw
    cyc(3'b010, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(3'b000, 0, 0, 0);
    chk("mask_req", 32'(bus.int_req), 32'h0);
    chk("mask_pend", 32'(bus.pending), 32'h2);
    cyc(3'b000, 1, 0, 0);
    chk("unmask_req", 32'(bus.int_req), 32'h1);
    cyc(3'b000, 0, 0, 0);
    chk("withdraw_req", 32'(bus.int_req), 32'h0);
    chk("withdraw_pend", 32'(bus.pending), 32'h2);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 1, 0);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 0, 1);

    // Ack and fresh edge of the same source in one cycle
    cyc(3'b010, 1, 0, 0);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 0, 0);
    chk("same_req", 32'(bus.int_req), 32'h1);
    cyc(3'b010, 1, 0, 0);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 1, 0);
    chk("same_pend", 32'(bus.pending), 32'h2);
    chk("same_isr", 32'(bus.in_service), 32'h2);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 0, 0);
    chk("same_level_blocked", 32'(bus.int_req), 32'h0);
    cyc(3'b000, 1, 0, 1);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 1, 0);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 0, 1);

    // eret and ack together
    cyc(3'b001, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 1, 0);
    cyc(3'b100, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(3'b000, 1, 0, 0);
    chk("eretack_id", 32'(bus.int_id), 32'h2);
    cyc(3'b000, 1, 1, 1);
    chk("eretack_isr", 32'(bus.in_service), 32'h4);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b000, 1, 0, 1);

    // Reset in the middle of a request
    cyc(3'b100, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(3'b000, 1, 0, 0);
    chk("midreq_req", 32'(bus.int_req), 32'h1);
`ifdef IRQ_VECTOR_EN
    chk("midreq_vec", bus.int_vec, 32'h120);
`endif
    async_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [NUM_IRQ-1:0] rv;
      logic               ackv;
      rv = '0;
      for (int b = 0; b < NUM_IRQ; b++) rv[b] = ($urandom_range(0, 7) == 0);
      ackv = m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      cyc(rv, $urandom_range(0, 9) != 0, ackv, $urandom_range(0, 11) == 0);
      if (n == 700) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
